// File: rtl/serial_digit_adder.sv
// Digit-serial adder: adds WIDTH-bit operands DIGIT bits per clock with valid/ready handshakes.
// Optional subtract mode is enabled by defining ADDER_SUB_EN.
module serial_digit_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             acc_mode,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] b_src;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] res_next;
  logic             cmsb;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CW'(N - 1));
  assign b_src  = acc_mode ? acc : b;

`ifdef ADDER_SUB_EN
  assign b_eff   = sub ? ~b_src : b_src;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b_src;
  assign cin_eff = cin;
`endif

  // One ripple slice; the new digit enters the result from the top.
  assign dsum     = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + (DIGIT + 1)'(carry);
  assign res_next = WIDTH'({dsum[DIGIT-1:0], res} >> DIGIT);
  // Carry into the digit MSB recovered from its sum and operand bits.
  assign cmsb     = dsum[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = RUN;
      RUN:     if (last) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= next_state;
      in_ready  <= (next_state == IDLE);
      out_valid <= (next_state == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= a;
            b_sh  <= b_eff;
            carry <= cin_eff;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          res   <= res_next;
          carry <= dsum[DIGIT];
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum      <= res_next;
            acc      <= res_next;
            cout     <= dsum[DIGIT];
            overflow <= cmsb ^ dsum[DIGIT];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_digit_adder.sv
// Directed bench for serial_digit_adder: instance 0 has DIGIT=1, instance 1 has DIGIT=4 (WIDTH=8).
// Subtract vectors run only when ADDER_SUB_EN is defined.
module tb_serial_digit_adder;

  logic       clk;
  logic       rst;
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] a         [2];
  logic [7:0] b         [2];
  logic       cin       [2];
  logic       acc_mode  [2];
`ifdef ADDER_SUB_EN
  logic       sub       [2];
`endif
  logic       out_valid [2];
  logic       out_ready [2];
  logic [7:0] sum       [2];
  logic       cout      [2];
  logic       overflow  [2];

  int tests = 0;
  int fails = 0;

  serial_digit_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .cin(cin[0]), .acc_mode(acc_mode[0]),
`ifdef ADDER_SUB_EN
    .sub(sub[0]),
`endif
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum(sum[0]), .cout(cout[0]), .overflow(overflow[0])
  );

  serial_digit_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .cin(cin[1]), .acc_mode(acc_mode[1]),
`ifdef ADDER_SUB_EN
    .sub(sub[1]),
`endif
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum(sum[1]), .cout(cout[1]), .overflow(overflow[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands, wait (bounded) for in_ready and leave once the accept edge has passed.
  task automatic start(input int d, input logic [7:0] av, input logic [7:0] bv,
                       input logic c, input logic am, input logic sb);
    int k;
    a[d] = av; b[d] = bv; cin[d] = c; acc_mode[d] = am;
`ifdef ADDER_SUB_EN
    sub[d] = sb;
`else
    if (sb) $display("note: subtract requested without ADDER_SUB_EN");
`endif
    in_valid[d] = 1'b1;
    k = 0;
    while (!in_ready[d] && k < 20) begin
      step();
      k++;
    end
    if (k >= 20) check("in_ready_timeout", 16'(k), 16'(0));
    step();
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input string tag, input int n_exp);
    int lat;
    lat = 0;
    while (!out_valid[d] && lat < 40) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 16'(lat), 16'(n_exp));
  endtask

  task automatic handshake(input int d, input string tag);
    out_ready[d] = 1'b1;
    step();
    out_ready[d] = 1'b0;
    check({tag, "_ov_after_hs"}, 16'(out_valid[d]), 16'(0));
    check({tag, "_ir_after_hs"}, 16'(in_ready[d]), 16'(1));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; a[d] = '0; b[d] = '0; cin[d] = 1'b0; acc_mode[d] = 1'b0;
      out_ready[d] = 1'b0;
`ifdef ADDER_SUB_EN
      sub[d] = 1'b0;
`endif
    end
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", 16'(in_ready[0]), 16'(1));
    check("rst_out_valid", 16'(out_valid[0]), 16'(0));
    check("rst_sum", 16'(sum[0]), 16'h00);
    check("rst_cout_ovf", {14'd0, cout[0], overflow[0]}, 16'd0);
    check("rst_in_ready_d4", 16'(in_ready[1]), 16'(1));

    // Reset mid-RUN, then accumulator must read back as zero
    start(0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    check("run_in_ready_low", 16'(in_ready[0]), 16'(0));
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", 16'(out_valid[0]), 16'(0));
    check("midrst_in_ready", 16'(in_ready[0]), 16'(1));
    check("midrst_sum", 16'(sum[0]), 16'h00);
    start(0, 8'h05, 8'h77, 1'b0, 1'b1, 1'b0);
    wait_done(0, "acc_after_rst", 8);
    check("acc_after_rst_sum", 16'(sum[0]), 16'h05);
    handshake(0, "acc_after_rst");

    // Basic add with carry-in and signed overflow
    start(0, 8'h3C, 8'h5A, 1'b1, 1'b0, 1'b0);
    wait_done(0, "basic", 8);
    check("basic_sum", 16'(sum[0]), 16'h97);
    check("basic_cout", 16'(cout[0]), 16'(0));
    check("basic_ovf", 16'(overflow[0]), 16'(1));
    handshake(0, "basic");

    // Carry wrap with 4-bit digits
    start(1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    wait_done(1, "wrap", 2);
    check("wrap_sum", 16'(sum[1]), 16'h00);
    check("wrap_cout", 16'(cout[1]), 16'(1));
    check("wrap_ovf", 16'(overflow[1]), 16'(0));
    handshake(1, "wrap");

    // Positive + positive overflowing into the sign bit, 4-bit digits
    start(1, 8'h70, 8'h10, 1'b0, 1'b0, 1'b0);
    wait_done(1, "ovf4", 2);
    check("ovf4_sum", 16'(sum[1]), 16'h80);
    check("ovf4_cout_ovf", {14'd0, cout[1], overflow[1]}, 16'b01);
    handshake(1, "ovf4");

    // Backpressure holds the result, then accumulate onto it
    start(0, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
    wait_done(0, "bp", 8);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_sum", 16'(sum[0]), 16'h30);
      check("bp_hold_valid", 16'(out_valid[0]), 16'(1));
    end
    handshake(0, "bp");
    start(0, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0);
    wait_done(0, "accum", 8);
    check("accum_sum", 16'(sum[0]), 16'h35);
    handshake(0, "accum");

`ifdef ADDER_SUB_EN
    start(0, 8'h05, 8'h07, 1'b1, 1'b0, 1'b1);
    wait_done(0, "sub1", 8);
    check("sub1_sum", 16'(sum[0]), 16'hFE);
    check("sub1_cout_ovf", {14'd0, cout[0], overflow[0]}, 16'b00);
    handshake(0, "sub1");
    start(0, 8'h80, 8'h01, 1'b0, 1'b0, 1'b1);
    wait_done(0, "sub2", 8);
    check("sub2_sum", 16'(sum[0]), 16'h7F);
    check("sub2_cout_ovf", {14'd0, cout[0], overflow[0]}, 16'b11);
    handshake(0, "sub2");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_digit_adder.md
# serial_digit_adder

Parametrised multi-cycle adder that is the successor to the team's single-bit full adder. It adds two WIDTH-bit operands DIGIT bits per clock through a registered carry chain, with a valid/ready handshake on input and output. An internal accumulator lets results be chained across transactions. It sits between the operand source and the result consumer, and trades latency for a small, narrow ripple slice.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits processed per cycle (1..WIDTH). N = WIDTH/DIGIT is the number of digit cycles.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- in_valid, input, 1, operands and mode are presented.
- in_ready, output, 1, block can accept operands.
- a, input, WIDTH, operand A (unsigned or two's complement).
- b, input, WIDTH, operand B.
- cin, input, 1, carry-in to bit 0.
- acc_mode, input, 1, 1 = use internal accumulator in place of b.
- sub, input, 1, present only with ADDER_SUB_EN; 1 = subtract.
- out_valid, output, 1, result is available.
- out_ready, input, 1, consumer accepts the result.
- sum, output, WIDTH, result.
- cout, output, 1, carry out of bit WIDTH-1.
- overflow, output, 1, signed overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, the block latches a and the effective B (acc when acc_mode=1, else b), and latches cin.
  - It clears the digit counter to 0 and moves to RUN.
- RUN:
  - in_ready=0.
  - Each cycle it adds digit k of A and B plus the carry register, writes DIGIT sum bits into the result shift register, and updates the carry register.
  - The counter increments each cycle. After digit N-1 the block moves to DONE.
  - The carry into the MSB is captured during the final digit so overflow can be computed.
- DONE:
  - out_valid=1. sum, cout and overflow are stable.
  - The accumulator register is loaded with sum on entry to DONE.
  - On out_valid&&out_ready the block moves to IDLE.
- Arithmetic: sum = (A + B + cin) mod 2^WIDTH, and cout = bit WIDTH of the full sum.
- out_ready while out_valid=0 is ignored. in_valid outside IDLE is ignored; the source must hold its data until in_ready.
- Reset (any state, including mid-RUN):
  - Aborts the operation and sets state to IDLE.
  - Clears the accumulator, carry register and counter to 0.
  - Sets sum=0, cout=0, overflow=0, out_valid=0 and in_ready=1 in the cycle after rst is sampled high.

## Timing
- Acceptance edge E0. RUN occupies edges E1..EN. out_valid is high after edge EN, i.e. N cycles after acceptance.
  - Example: WIDTH=8, DIGIT=1 gives 8 cycles. WIDTH=8, DIGIT=4 gives 2 cycles.
- DIGIT=WIDTH gives N=1: one RUN cycle, then DONE.
- Output is held indefinitely while out_ready=0.
- DONE to IDLE takes one edge. in_ready reasserts the cycle after the output handshake, so there is one bubble between transactions.
- Throughput is one result per N+2 cycles with out_ready tied high.
- The accumulator value used by acc_mode is the result of the most recently completed transaction. After reset it is 0.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- ADDER_SUB_EN defined:
  - The sub port exists.
  - sub=1 at acceptance computes A + ~B + 1, and cin is ignored.
  - cout=1 means no borrow. overflow follows the same MSB-carry rule as addition.
- ADDER_SUB_EN undefined:
  - The sub port is absent and the block only adds.
  - The logic size matches the add-only datapath.

## Test plan
- Reset mid-RUN: WIDTH=8, DIGIT=1, accept a=0xFF, b=0x01, assert rst at cycle 3 -> next cycle out_valid=0, in_ready=1, sum=0, and a following acc_mode add of a=0x05 yields 0x05.
- Basic add: WIDTH=8, DIGIT=1, a=0x3C, b=0x5A, cin=1 -> out_valid after 8 cycles, sum=0x97, cout=0, overflow=1.
- Carry/wrap: WIDTH=8, DIGIT=4, a=0xFF, b=0x01, cin=0 -> out_valid after 2 cycles, sum=0x00, cout=1, overflow=0.
- Accumulate with backpressure: a=0x10, b=0x20, hold out_ready=0 for 5 cycles -> sum stays 0x30 with out_valid=1; then out_ready=1, next transaction a=0x05 with acc_mode=1 -> sum=0x35.
- Subtract (ADDER_SUB_EN): a=0x05, b=0x07, sub=1, cin=1 -> sum=0xFE, cout=0, overflow=0; a=0x80, b=0x01 -> sum=0x7F, overflow=1.
